execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  EX stage of the 5-stage MIPS pipeline; consumer of the ID/EX latch outputs from decode.
//  Decodes ALU control, runs the ALU, computes the branch target and selects the destination register.
//  Registers everything into the EX/MEM latch for the memory stage.
//  stall and flush inputs let the hazard unit hold the latch or insert a bubble.
// PARAMETERS
//  DW  32  datapath width; the branch-target shift and sign-ext fields assume 32
//  RW  5   register-index width
// PORTS
//  clk               in   1   clock, rising edge
//  rst               in   1   reset, synchronous, active-high
//  stall             in   1   hold EX/MEM latch contents
//  flush             in   1   load bubble (control fields zero) into EX/MEM
//  id_ex_wb          in   2   {RegWrite, MemToReg}
//  id_ex_mem         in   3   {Branch, MemRead, MemWrite}
//  id_ex_execute     in   4   {RegDst, ALUOp[1:0], ALUSrc}
//  id_ex_npc         in   DW  PC+4 of the instruction
//  id_ex_readdat1    in   DW  rs value
//  id_ex_readdat2    in   DW  rt value
//  id_ex_sign_ext    in   DW  sign-extended imm16; [5:0] = funct
//  id_ex_instr_bits_20_16 in RW  rt index
//  id_ex_instr_bits_15_11 in RW  rd index
//  ex_mem_wb         out  2   registered wb control
//  ex_mem_mem        out  3   registered mem control
//  ex_mem_btgt       out  DW  branch target
//  ex_mem_zero       out  1   ALU result == 0
//  ex_mem_alu_result out  DW  ALU result
//  ex_mem_readdat2   out  DW  rt value (store data)
//  ex_mem_write_reg  out  RW  destination register index
// BEHAVIOUR
//  Combinational front end:
//  - Operand B = ALUSrc ? sign_ext : readdat2; operand A = readdat1.
//  - ALUOp 00 -> add; 01 -> sub; 10 -> by funct:
//    100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed).
//  - ALUOp 11, or unlisted funct -> result 0.
//  - add/sub wrap mod 2^32; no overflow trap; slt result is 32'd1 or 32'd0.
//  - btgt = npc + (sign_ext << 2), mod 2^32; zero = (result == 0).
//  - write_reg = RegDst ? bits_15_11 : bits_20_16.
//  EX/MEM latch, updated at each rising clk edge; priority rst > flush > stall > load:
//  - rst: all outputs 0; ex_mem_zero is also 0, not derived.
//  - flush: ex_mem_wb=0 and ex_mem_mem=0; data fields load normally.
//  - stall (no flush): every output holds its value.
//  - otherwise: load all front-end values.
//  - Latency: one cycle, ID/EX inputs to EX/MEM outputs. No internal state beyond the latch.
//  - flush and stall asserted together: flush wins; the bubble is written.
//  - Reset mid-stream discards the in-flight instruction. The first post-reset edge with
//    rst low loads the current inputs.
//  - Inputs are X-free once rst is deasserted; an undefined funct never produces X
//    (default arm applies).
// TESTING
//  - rst=1 one edge -> all outputs 0; then a NOP bundle (all ctl 0) -> outputs stay 0 except
//    data fields.
//  - R-type add: ex=1100, funct=100000, r1=5, r2=7, rd=3 -> next edge
//    alu_result=12, write_reg=3, wb=10, zero=0.
//  - R-type sub/slt: 5-5 -> result 0, zero=1.
//    slt with A=-1 (FFFFFFFF), B=1 -> result 1.
//  - LW: ex=0001, r1=0x100, sign_ext=0xFFFFFFFC, rt=8 -> result 0xFC, write_reg=8, wb=11, mem=010.
//  - BEQ: ex=0100, npc=0x40, sign_ext=3, r1=r2=9 -> btgt=0x4C, zero=1, mem=100.
//    npc=0x40 with sign_ext=-1 -> btgt=0x3C.
//  - Hazard controls: stall=1 for 2 cycles with changing inputs -> outputs frozen.
//    flush=1 with stall=1 -> wb=0, mem=0 after that edge.

Source files
------------

// File: rtl/execute_stage.sv
// EX stage of the 5-stage MIPS pipeline: ALU control decode, ALU, branch target,
// destination-register select, and the EX/MEM pipeline latch with stall/flush.
module execute_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic [1:0]    id_ex_wb,
    input  logic [2:0]    id_ex_mem,
    input  logic [3:0]    id_ex_execute,
    input  logic [DW-1:0] id_ex_npc,
    input  logic [DW-1:0] id_ex_readdat1,
    input  logic [DW-1:0] id_ex_readdat2,
    input  logic [DW-1:0] id_ex_sign_ext,
    input  logic [RW-1:0] id_ex_instr_bits_20_16,
    input  logic [RW-1:0] id_ex_instr_bits_15_11,
    output logic [1:0]    ex_mem_wb,
    output logic [2:0]    ex_mem_mem,
    output logic [DW-1:0] ex_mem_btgt,
    output logic          ex_mem_zero,
    output logic [DW-1:0] ex_mem_alu_result,
    output logic [DW-1:0] ex_mem_readdat2,
    output logic [RW-1:0] ex_mem_write_reg
);

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_ZERO
    } alu_op_e;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    logic          reg_dst;
    logic [1:0]    alu_ctl;
    logic          alu_src;
    logic [5:0]    funct;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    alu_op_e       alu_op;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] btgt;
    logic [RW-1:0] write_reg;

    assign reg_dst = id_ex_execute[3];
    assign alu_ctl = id_ex_execute[2:1];
    assign alu_src = id_ex_execute[0];
    assign funct   = id_ex_sign_ext[5:0];

    assign op_a = id_ex_readdat1;
    assign op_b = alu_src ? id_ex_sign_ext : id_ex_readdat2;

    always_comb begin
        // NOTE: default first so every path assigns alu_op and no latch is inferred.
        alu_op = ALU_ZERO;
        case (alu_ctl)
            2'b00: alu_op = ALU_ADD;
            2'b01: alu_op = ALU_SUB;
            2'b10: begin
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ZERO;
                endcase
            end
            default: alu_op = ALU_ZERO;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = op_a + op_b;
            ALU_SUB: alu_result = op_a - op_b;
            ALU_AND: alu_result = op_a & op_b;
            ALU_OR:  alu_result = op_a | op_b;
            ALU_SLT: alu_result = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_result = '0;
        endcase
    end

    // Word-aligned branch offset relative to PC+4.
    assign btgt      = id_ex_npc + (id_ex_sign_ext << 2);
    assign write_reg = reg_dst ? id_ex_instr_bits_15_11 : id_ex_instr_bits_20_16;

    // Flush beats stall so a bubble is always written when the hazard unit asks for one.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every latch field sampled on the same edge.
        if (rst) begin
            ex_mem_wb         <= '0;
            ex_mem_mem        <= '0;
            ex_mem_btgt       <= '0;
            ex_mem_zero       <= 1'b0;
            ex_mem_alu_result <= '0;
            ex_mem_readdat2   <= '0;
            ex_mem_write_reg  <= '0;
        end else if (flush || !stall) begin
            ex_mem_wb         <= flush ? 2'b00 : id_ex_wb;
            ex_mem_mem        <= flush ? 3'b000 : id_ex_mem;
            ex_mem_btgt       <= btgt;
            ex_mem_zero       <= (alu_result == '0);
            ex_mem_alu_result <= alu_result;
            ex_mem_readdat2   <= id_ex_readdat2;
            ex_mem_write_reg  <= write_reg;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus randomized traffic
// compared against a behavioural model of the EX/MEM latch.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_mem;
    logic [3:0]  id_ex_execute;
    logic [31:0] id_ex_npc, id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext;
    logic [4:0]  id_ex_instr_bits_20_16, id_ex_instr_bits_15_11;
    logic [1:0]  ex_mem_wb;
    logic [2:0]  ex_mem_mem;
    logic [31:0] ex_mem_btgt, ex_mem_alu_result, ex_mem_readdat2;
    logic        ex_mem_zero;
    logic [4:0]  ex_mem_write_reg;

    typedef struct {
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [31:0] btgt;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  wr;
    } ex_mem_t;

    ex_mem_t exp_q;
    int      n_pass = 0;
    int      n_total = 0;

    execute_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_ex_wb(id_ex_wb), .id_ex_mem(id_ex_mem), .id_ex_execute(id_ex_execute),
        .id_ex_npc(id_ex_npc), .id_ex_readdat1(id_ex_readdat1),
        .id_ex_readdat2(id_ex_readdat2), .id_ex_sign_ext(id_ex_sign_ext),
        .id_ex_instr_bits_20_16(id_ex_instr_bits_20_16),
        .id_ex_instr_bits_15_11(id_ex_instr_bits_15_11),
        .ex_mem_wb(ex_mem_wb), .ex_mem_mem(ex_mem_mem), .ex_mem_btgt(ex_mem_btgt),
        .ex_mem_zero(ex_mem_zero), .ex_mem_alu_result(ex_mem_alu_result),
        .ex_mem_readdat2(ex_mem_readdat2), .ex_mem_write_reg(ex_mem_write_reg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want)
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        else
            n_pass++;
    endtask

    // Reference ALU straight from the instruction-set rules.
    function automatic logic [31:0] ref_alu(input logic [1:0] aop, input logic [5:0] fn,
                                            input logic [31:0] a, input logic [31:0] b);
        int signed sa, sb;
        sa = a;
        sb = b;
        if (aop == 2'd0) return a + b;
        if (aop == 2'd1) return a - b;
        if (aop == 2'd3) return 32'd0;
        case (fn)
            6'd32:   return a + b;
            6'd34:   return a - b;
            6'd36:   return a & b;
            6'd37:   return a | b;
            6'd42:   return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic ex_mem_t front_end();
        ex_mem_t f;
        logic [31:0] b;
        b      = id_ex_execute[0] ? id_ex_sign_ext : id_ex_readdat2;
        f.wb   = id_ex_wb;
        f.mem  = id_ex_mem;
        f.alu  = ref_alu(id_ex_execute[2:1], id_ex_sign_ext[5:0], id_ex_readdat1, b);
        f.zero = (f.alu == 32'd0);
        f.btgt = id_ex_npc + id_ex_sign_ext * 4;
        f.rd2  = id_ex_readdat2;
        f.wr   = id_ex_execute[3] ? id_ex_instr_bits_15_11 : id_ex_instr_bits_20_16;
        return f;
    endfunction

    // One clock: update the model from current inputs, let the edge pass, compare at negedge.
    task automatic cycle(input string tag);
        ex_mem_t f;
        f = front_end();
        if (rst) begin
            exp_q = '{wb: 2'b0, mem: 3'b0, btgt: 32'b0, zero: 1'b0, alu: 32'b0, rd2: 32'b0, wr: 5'b0};
        end else if (flush) begin
            exp_q     = f;
            exp_q.wb  = 2'b0;
            exp_q.mem = 3'b0;
        end else if (!stall) begin
            exp_q = f;
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, ".wb"},   {30'b0, ex_mem_wb},        {30'b0, exp_q.wb});
        check({tag, ".mem"},  {29'b0, ex_mem_mem},       {29'b0, exp_q.mem});
        check({tag, ".btgt"}, ex_mem_btgt,               exp_q.btgt);
        check({tag, ".zero"}, {31'b0, ex_mem_zero},      {31'b0, exp_q.zero});
        check({tag, ".alu"},  ex_mem_alu_result,         exp_q.alu);
        check({tag, ".rd2"},  ex_mem_readdat2,           exp_q.rd2);
        check({tag, ".wr"},   {27'b0, ex_mem_write_reg}, {27'b0, exp_q.wr});
    endtask

    task automatic set_in(input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] ex,
                          input logic [31:0] npc, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] se, input logic [4:0] rt, input logic [4:0] rd);
        id_ex_wb = wb; id_ex_mem = mem; id_ex_execute = ex;
        id_ex_npc = npc; id_ex_readdat1 = r1; id_ex_readdat2 = r2; id_ex_sign_ext = se;
        id_ex_instr_bits_20_16 = rt; id_ex_instr_bits_15_11 = rd;
    endtask

    task automatic randomize_inputs();
        logic [5:0] fns [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
        logic [31:0] se, r2;
        se = $urandom;
        if ($urandom_range(0, 3) != 0) se[5:0] = fns[$urandom_range(0, 5)];
        r2 = $urandom;
        set_in(2'($urandom), 3'($urandom), 4'($urandom), $urandom, $urandom, r2, se,
               5'($urandom), 5'($urandom));
        if ($urandom_range(0, 3) == 0) id_ex_readdat1 = r2;
        stall = ($urandom_range(0, 4) == 0);
        flush = ($urandom_range(0, 7) == 0);
        rst   = ($urandom_range(0, 39) == 0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        set_in(2'b11, 3'b111, 4'b1100, 32'h10, 32'h5, 32'h7, 32'h20, 5'd1, 5'd2);
        cycle("reset");
        check("reset.alu_const", ex_mem_alu_result, 32'd0);

        rst = 1'b0;
        set_in(2'b00, 3'b000, 4'b0000, 32'h8, 32'h11, 32'h22, 32'h4, 5'd6, 5'd9);
        cycle("nop");
        check("nop.wb_const", {30'b0, ex_mem_wb}, 32'd0);

        set_in(2'b10, 3'b000, 4'b1100, 32'h4, 32'd5, 32'd7, 32'h20, 5'd2, 5'd3);
        cycle("add");
        check("add.res_const", ex_mem_alu_result, 32'd12);
        check("add.wr_const",  {27'b0, ex_mem_write_reg}, 32'd3);

        set_in(2'b10, 3'b000, 4'b1100, 32'h4, 32'd5, 32'd5, 32'h22, 5'd2, 5'd3);
        cycle("sub");
        check("sub.zero_const", {31'b0, ex_mem_zero}, 32'd1);

        set_in(2'b10, 3'b000, 4'b1100, 32'h4, 32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd2, 5'd4);
        cycle("slt");
        check("slt.res_const", ex_mem_alu_result, 32'd1);

        set_in(2'b11, 3'b010, 4'b0001, 32'h4, 32'h100, 32'h0, 32'hFFFF_FFFC, 5'd8, 5'd1);
        cycle("lw");
        check("lw.res_const", ex_mem_alu_result, 32'h0000_00FC);

        set_in(2'b00, 3'b100, 4'b0100, 32'h40, 32'd9, 32'd9, 32'd3, 5'd1, 5'd1);
        cycle("beq");
        check("beq.btgt_const", ex_mem_btgt, 32'h4C);

        set_in(2'b00, 3'b100, 4'b0100, 32'h40, 32'd9, 32'd8, 32'hFFFF_FFFF, 5'd1, 5'd1);
        cycle("beq_neg");
        check("beq_neg.btgt_const", ex_mem_btgt, 32'h3C);

        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            randomize_inputs();
            rst = 1'b0; flush = 1'b0; stall = 1'b1;
            cycle("stall");
            check("stall.btgt_const", ex_mem_btgt, 32'h3C);
        end

        set_in(2'b11, 3'b111, 4'b1100, 32'h4, 32'd1, 32'd2, 32'h20, 5'd1, 5'd1);
        flush = 1'b1;
        cycle("flush_stall");
        check("flush_stall.mem_const", {29'b0, ex_mem_mem}, 32'd0);
        check("flush_stall.res_const", ex_mem_alu_result, 32'd3);
        stall = 1'b0; flush = 1'b0;

        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
